// File: rtl/chan_mux_pkg.sv
// Shared definitions for the chan_mux_rr channel selector.
// Holds the mode encodings and the output-register state type.
package chan_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

    // One-entry output register: EMPTY means out_valid=0, FULL means out_valid=1.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority finder: returns the first requesting index after i_ptr,
// wrapping from CH-1 back to 0. Purely combinational.
module rr_pick #(
    parameter  int CH    = 8,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic [CH-1:0]    i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    // Distance of each index from the slot after i_ptr; the closest requester wins.
    always_comb begin
        int best_d;
        int d;
        o_found = 1'b0;
        o_idx   = '0;
        best_d  = CH;
        d       = 0;
        for (int k = 0; k < CH; k++) begin
            d = (k + CH - int'(i_ptr) - 1) % CH;
            if (i_req[k] && (d < best_d)) begin
                best_d  = d;
                o_found = 1'b1;
                o_idx   = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// Registered N-channel selector with valid/ready handshake on both sides.
// Fixed mode takes the channel from sel; scan mode picks round-robin after
// the last scan grant. Optional even-parity output when CHAN_MUX_PARITY_EN
// is defined.
//
// Handshake: a word moves on any edge where valid and ready are both high.
// Upstream ready (in_ready) is the one-hot grant and is only raised when
// the output register can take a word (empty, or draining this cycle).
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter  int W     = 4,
    parameter  int CH    = 8,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [0:CH*W-1]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef CHAN_MUX_PARITY_EN
    output logic              out_par,
`endif
    output out_state_e        dbg_state
);

    out_state_e       r_state;
    out_state_e       w_state_nxt;
    logic [W-1:0]     r_data;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] r_ptr;
    logic             w_can_accept;
    logic             w_fix_hit;
    logic             w_scan_found;
    logic [SEL_W-1:0] w_scan_idx;
    logic             w_grant;
    logic [SEL_W-1:0] w_gidx;
    logic [W-1:0]     w_gdata;

    assign out_valid    = (r_state == ST_FULL);
    assign w_can_accept = !out_valid || out_ready;
    assign out_data     = r_data;
    assign out_ch       = r_ch;
    assign dbg_state    = r_state;

    rr_pick #(.CH(CH)) u_pick (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .o_found (w_scan_found),
        .o_idx   (w_scan_idx)
    );

    // Fixed-mode hit; a sel at or beyond CH matches no channel and never grants.
    always_comb begin
        w_fix_hit = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if ((sel == SEL_W'(k)) && in_valid[k]) w_fix_hit = 1'b1;
        end
    end

    // Grant decision, only when the output register can take a word.
    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        if (w_can_accept) begin
            if (mode == MODE_SCAN) begin
                w_grant = w_scan_found;
                w_gidx  = w_scan_idx;
            end else begin
                w_grant = w_fix_hit;
                w_gidx  = sel;
            end
        end
    end

    // Data mux and one-hot in_ready decode for the granted channel.
    always_comb begin
        w_gdata  = '0;
        in_ready = '0;
        for (int k = 0; k < CH; k++) begin
            if (w_gidx == SEL_W'(k)) w_gdata = in_data[k*W +: W];
            in_ready[k] = w_grant && (w_gidx == SEL_W'(k));
        end
    end

    // Output-register state: load on grant, empty on a drain without refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_grant) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Output payload, captured only on a grant so stalls hold it stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_ch   <= '0;
        end else if (w_grant) begin
            r_data <= w_gdata;
            r_ch   <= w_gidx;
        end
    end

    // Round-robin pointer; starts at CH-1 so channel 0 wins the first scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_ptr <= SEL_W'(CH - 1);
        else if (w_grant && mode == MODE_SCAN) r_ptr <= w_gidx;
    end

`ifdef CHAN_MUX_PARITY_EN
    // Even parity of the captured word, registered alongside out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       out_par <= 1'b0;
        else if (w_grant) out_par <= ^w_gdata;
    end
`endif

endmodule
